// File: rtl/digits_pkg.sv
// Shared definitions for the bitmap <-> seven-segment blocks: frame geometry,
// FSM state encoding, segment bit positions and the row-buffer decoder.
package digits_pkg;

  localparam int NUM_LINES = 5;
  localparam int ROW_W     = 5;
  localparam int SEG_W     = 7;

  // Segment bit positions inside the 7-bit code
  localparam int SEG_TOP   = 6;
  localparam int SEG_MID   = 0;
  localparam int SEG_BOT   = 3;
  localparam int SEG_UP_HI = 1;  // upper segment in the bit4 column
  localparam int SEG_UP_LO = 5;  // upper segment in the bit0 column
  localparam int SEG_DN_HI = 2;  // lower segment in the bit4 column
  localparam int SEG_DN_LO = 4;  // lower segment in the bit0 column

  // Bitmap columns sampled by the decoder
  localparam int COL_HI  = 4;
  localparam int COL_MID = 2;
  localparam int COL_LO  = 0;

  typedef enum logic [1:0] {COLLECT, DECODE, CHECK, OUTPUT} state_t;

  // Decode a full frame: each segment is read from one characteristic pixel.
  function automatic logic [SEG_W-1:0] decode_rows(
    input logic [NUM_LINES-1:0][ROW_W-1:0] rows
  );
    logic [SEG_W-1:0] s;
    s            = '0;
    s[SEG_TOP]   = rows[0][COL_MID];
    s[SEG_MID]   = rows[2][COL_MID];
    s[SEG_BOT]   = rows[4][COL_MID];
    s[SEG_UP_HI] = rows[1][COL_HI];
    s[SEG_UP_LO] = rows[1][COL_LO];
    s[SEG_DN_HI] = rows[3][COL_HI];
    s[SEG_DN_LO] = rows[3][COL_LO];
    return s;
  endfunction

endpackage

// File: rtl/segments_to_bitmap.sv
// Combinational encoder: seven-segment code + line index -> one bitmap row.
// Horizontal segments light the three middle pixels of their line; corner
// pixels on lines 0/2/4 are lit by an adjacent vertical segment only when the
// horizontal segment of that line is off (rounded-corner font).
// Only compiled into the design when BITMAP_CHECK_EN is defined.
`ifdef BITMAP_CHECK_EN
module segments_to_bitmap
  import digits_pkg::*;
(
  input  logic [SEG_W-1:0] segments,
  input  logic [2:0]       line,
  output logic [ROW_W-1:0] row
);

  logic top, mid, bot, up_hi, up_lo, dn_hi, dn_lo;

  assign top   = segments[SEG_TOP];
  assign mid   = segments[SEG_MID];
  assign bot   = segments[SEG_BOT];
  assign up_hi = segments[SEG_UP_HI];
  assign up_lo = segments[SEG_UP_LO];
  assign dn_hi = segments[SEG_DN_HI];
  assign dn_lo = segments[SEG_DN_LO];

  // Row pattern selected by line index
  always_comb begin
    row = '0;
    case (line)
      3'd0:    row = {up_hi & ~top, {3{top}}, up_lo & ~top};
      3'd1:    row = {up_hi, 3'b000, up_lo};
      3'd2:    row = {(up_hi | dn_hi) & ~mid, {3{mid}}, (up_lo | dn_lo) & ~mid};
      3'd3:    row = {dn_hi, 3'b000, dn_lo};
      3'd4:    row = {dn_hi & ~bot, {3{bot}}, dn_lo & ~bot};
      default: row = '0;
    endcase
  end

endmodule
`endif

// File: rtl/bitmap_to_segments.sv
// Collects a 5x5 bitmap row by row, decodes it to a seven-segment code and
// presents it on a valid/ready output. With BITMAP_CHECK_EN defined, the
// decoded code is re-encoded line by line and compared with the stored
// bitmap; any difference raises seg_error. Without it, seg_error is 0.
// seg_valid rises one cycle after entering OUTPUT so the presented code and
// error flag are already settled registers when the consumer sees them.
module bitmap_to_segments
  import digits_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [ROW_W-1:0] row_bits,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic [SEG_W-1:0] segments,
  output logic             seg_error
);

  localparam logic [2:0] LAST_LINE = 3'(NUM_LINES - 1);

  state_t                          state;
  logic [2:0]                      line;
  logic [NUM_LINES-1:0][ROW_W-1:0] rows;

`ifdef BITMAP_CHECK_EN
  logic             err;
  logic [ROW_W-1:0] enc_row;

  segments_to_bitmap u_enc (
    .segments (segments),
    .line     (line),
    .row      (enc_row)
  );

  assign seg_error = err;
`else
  assign seg_error = 1'b0;
`endif

  // Ready only while collecting, and held low throughout reset
  assign row_ready = (state == COLLECT) && !rst;

  // Frame FSM: collect rows, decode, optionally check, then hand off
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      line      <= '0;
      rows      <= '0;
      segments  <= '0;
      seg_valid <= 1'b0;
`ifdef BITMAP_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (row_valid) begin
            rows[line] <= row_bits;
            if (line == LAST_LINE) begin
              line  <= '0;
              state <= DECODE;
            end else begin
              line <= line + 3'd1;
            end
          end
        end
        DECODE: begin
          segments <= decode_rows(rows);
`ifdef BITMAP_CHECK_EN
          state    <= CHECK;
`else
          state    <= OUTPUT;
`endif
        end
`ifdef BITMAP_CHECK_EN
        CHECK: begin
          if (enc_row != rows[line]) err <= 1'b1;
          if (line == LAST_LINE) begin
            line  <= '0;
            state <= OUTPUT;
          end else begin
            line <= line + 3'd1;
          end
        end
`endif
        OUTPUT: begin
          if (!seg_valid) begin
            seg_valid <= 1'b1;
          end else if (seg_ready) begin
            seg_valid <= 1'b0;
            line      <= '0;
            state     <= COLLECT;
`ifdef BITMAP_CHECK_EN
            err       <= 1'b0;
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_to_segments.sv
// Directed bench for bitmap_to_segments; expectations follow BITMAP_CHECK_EN.
module tb_bitmap_to_segments;

`ifdef BITMAP_CHECK_EN
  localparam int   LAT = 7;
  localparam logic CHK = 1'b1;
`else
  localparam int   LAT = 2;
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       row_valid;
  logic       row_ready;
  logic [4:0] row_bits;
  logic       seg_valid;
  logic       seg_ready;
  logic [6:0] segments;
  logic       seg_error;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int frames = 0;

  bitmap_to_segments dut (
    .clk       (clk),
    .rst       (rst),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_bits  (row_bits),
    .seg_valid (seg_valid),
    .seg_ready (seg_ready),
    .segments  (segments),
    .seg_error (seg_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (seg_valid && seg_ready) frames <= frames + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rows: row0 in bits [24:20] ... row4 in bits [4:0]
  task automatic send_frame(input logic [24:0] r, input bit toggle, output int last);
    last = 0;
    for (int i = 0; i < 5; i++) begin
      if (toggle) begin
        row_valid = 1'b0;
        row_bits  = 5'b11111;
        step();
      end
      row_valid = 1'b1;
      row_bits  = r[24-5*i -: 5];
      step();
      last = cyc;
    end
    row_valid = 1'b0;
    row_bits  = '0;
  endtask

  task automatic await_out(input string tag, input int last);
    int k = 0;
    while (!seg_valid && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, cyc - last, LAT);
    chk({tag, "_row_ready_busy"}, row_ready, 1'b0);
  endtask

  task automatic consume(input string tag);
    seg_ready = 1'b1;
    step();
    seg_ready = 1'b0;
    chk({tag, "_valid_drop"}, seg_valid, 1'b0);
    chk({tag, "_row_ready_back"}, row_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [24:0] r, input logic [6:0] exp_seg,
                     input logic exp_err, input bit toggle);
    int last;
    send_frame(r, toggle, last);
    await_out(tag, last);
    chk({tag, "_segments"}, segments, exp_seg);
    chk({tag, "_seg_error"}, seg_error, exp_err);
    consume(tag);
  endtask

  initial begin
    int last;
    int f0;
    int seen;
    rst       = 1'b1;
    row_valid = 1'b0;
    row_bits  = '0;
    seg_ready = 1'b0;
    step();
    chk("rst_row_ready", row_ready, 1'b0);
    chk("rst_seg_valid", seg_valid, 1'b0);
    chk("rst_segments", segments, 7'h00);
    chk("rst_seg_error", seg_error, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_row_ready", row_ready, 1'b1);

    run("eight",   25'b01110_10001_01110_10001_01110, 7'h7F, 1'b0, 1'b0);
    run("one_l",   25'b10000_10000_10000_10000_10000, 7'h06, 1'b0, 1'b0);
    run("blank",   25'b00000_00000_00000_00000_00000, 7'h00, 1'b0, 1'b0);
    run("full",    25'b11111_11111_11111_11111_11111, 7'h7F, CHK,  1'b0);
    run("one_r",   25'b00001_00001_00001_00001_00001, 7'h30, 1'b0, 1'b0);
    run("zero",    25'b01110_10001_10001_10001_01110, 7'h7E, 1'b0, 1'b0);
    run("dot_top", 25'b00100_00000_00000_00000_00000, 7'h40, CHK,  1'b0);

    // Consumer stalls for 3 cycles while rows keep arriving
    f0 = frames;
    send_frame(25'b01110_10001_01110_10001_01110, 1'b0, last);
    await_out("stall", last);
    row_valid = 1'b1;
    row_bits  = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", seg_valid, 1'b1);
      chk("stall_segments", segments, 7'h7F);
      chk("stall_seg_error", seg_error, 1'b0);
      chk("stall_row_ready", row_ready, 1'b0);
    end
    row_valid = 1'b0;
    row_bits  = '0;
    consume("stall");
    chk("stall_single_transfer", frames, f0 + 1);
    step();
    chk("stall_no_repeat", frames, f0 + 1);

    // Reset after two accepted rows
    row_valid = 1'b1;
    row_bits  = 5'b11111;
    step();
    step();
    row_valid = 1'b0;
    rst       = 1'b1;
    step();
    chk("midrst_valid", seg_valid, 1'b0);
    rst = 1'b0;
    f0  = frames;
    run("midrst", 25'b10000_10000_10000_10000_10000, 7'h06, 1'b0, 1'b0);
    chk("midrst_one_frame", frames, f0 + 1);

    // Reset while a frame is pending in OUTPUT
    send_frame(25'b11111_11111_11111_11111_11111, 1'b0, last);
    await_out("outrst", last);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("outrst_valid", seg_valid, 1'b0);
    chk("outrst_segments", segments, 7'h00);
    chk("outrst_row_ready", row_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (seg_valid) seen++;
    end
    chk("outrst_no_pulse", seen, 0);

    // row_valid toggling every cycle with junk on idle cycles
    f0 = frames;
    run("toggle", 25'b10000_10000_10000_10000_10000, 7'h06, 1'b0, 1'b1);
    chk("toggle_one_frame", frames, f0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmap_to_segments.md
BITMAP_TO_SEGMENTS -- requirements
Module: bitmap_to_segments

Interface
REQ-001 SHALL have no parameters; geometry fixed at 5 rows x 5 bits, 7 segments.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port row_valid  input  1  row_bits holds a valid bitmap row.
REQ-005 SHALL have port row_ready  output  1  block accepts a row this cycle.
REQ-006 SHALL have port row_bits  input  5  one bitmap row; bit4 = segment-1/2 column, bit0 = segment-5/4 column.
REQ-007 SHALL have port seg_valid  output  1  segments/seg_error hold a decoded frame.
REQ-008 SHALL have port seg_ready  input  1  consumer takes the frame.
REQ-009 SHALL have port segments  output  7  decoded code; bit6 top, bit0 middle, bit3 bottom, bit1/bit5 upper columns, bit2/bit4 lower columns.
REQ-010 SHALL have port seg_error  output  1  frame is not a legal segment bitmap.

Function
REQ-011 SHALL transfer a row on clock edges where row_valid && row_ready.
REQ-012 SHALL accept rows in line order 0..4 using an internal 3-bit line counter, stored in a 5x5 row buffer.
REQ-013 SHALL use FSM states COLLECT, DECODE, CHECK, OUTPUT; reset state COLLECT.
REQ-014 SHALL assert row_ready only in COLLECT; COLLECT -> DECODE on acceptance of line 4.
REQ-015 SHALL in DECODE (one cycle) register segments: bit6=row0[2], bit0=row2[2], bit3=row4[2], bit1=row1[4], bit5=row1[0], bit2=row3[4], bit4=row3[0].
REQ-016 SHALL in CHECK spend exactly 5 cycles, one per line 0..4, comparing the stored row with the re-encoded row for the decoded segments; any mismatch sets seg_error.
REQ-017 SHALL assert seg_valid only in OUTPUT, with segments and seg_error stable until seg_ready is sampled high.
REQ-018 SHALL on seg_valid && seg_ready return to COLLECT, clearing line counter and seg_error; row_ready high on the next cycle.
REQ-019 SHALL give latency: last row accepted at edge N -> seg_valid high after edge N+7 with check compiled in, after edge N+2 without.
REQ-020 SHALL ignore row_valid and row_bits outside COLLECT; no row is lost or duplicated under row_valid toggling.

Reset
REQ-021 SHALL on rst: state COLLECT, line counter 0, row buffer 0, segments 7'h00, seg_error 0, seg_valid 0, row_ready 0 during rst and 1 on the first cycle after.
REQ-022 SHALL on rst mid-frame or during OUTPUT discard the partial or pending frame with no seg_valid pulse.

Configuration
REQ-023 SHALL with BITMAP_CHECK_EN defined include CHECK state, encoder and seg_error logic per REQ-016.
REQ-024 SHALL without BITMAP_CHECK_EN go DECODE -> OUTPUT directly and tie seg_error to 0.

Structure
REQ-025 SHALL take the FSM state enum, NUM_LINES=5, ROW_W=5, SEG_W=7 and the segment bit-index constants from shared package digits_pkg.
REQ-026 SHALL instantiate the existing combinational encoder segments_to_bitmap as the single sub-module for CHECK, driven by registered segments and the check line counter.

Verification
REQ-027 SHALL pass: rows 01110,10001,01110,10001,01110 -> segments 7'h7F, seg_error 0.
REQ-028 SHALL pass: rows 10000 x5 -> segments 7'h06, seg_error 0; rows 00000 x5 -> 7'h00, seg_error 0.
REQ-029 SHALL pass: rows 11111 x5 -> segments 7'h7F, seg_error 1 with BITMAP_CHECK_EN, 0 without.
REQ-030 SHALL pass: seg_ready low 3 cycles in OUTPUT -> segments and seg_error stable, row_ready 0, single transfer on release.
REQ-031 SHALL pass: rst after 2 rows accepted, then rows 10000 x5 -> exactly one frame, segments 7'h06.
REQ-032 SHALL pass: row_valid toggling every cycle during COLLECT -> same result and latency per REQ-019 counted from last accepted row.
